// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter/sequencer.
// Opcode values are the def.v encodings this block and its users rely on.
package alu_arbiter_pkg;

    localparam int unsigned CntW = 3;

    localparam logic [5:0] AluNop  = 6'h3F;
    localparam logic [5:0] AluAdda = 6'h00;
    localparam logic [5:0] AluSuba = 6'h01;
    localparam logic [5:0] AluAnda = 6'h02;
    localparam logic [5:0] AluOra  = 6'h03;
    localparam logic [5:0] AluAsla = 6'h04;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2,
        ArbResp  = 2'd3
    } arb_state_e;

    // Round-robin pick: on a tie the port that did not win last time goes next.
    function automatic logic arb_grant(input logic valid0, input logic valid1,
                                       input logic last_grant);
        if (valid0 && valid1) begin
            return ~last_grant;
        end
        return valid1;
    endfunction

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences one transaction at a time from two requesters
// through a shared registered ALU and returns each result as a one-cycle pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DataW  = 8,
    parameter int unsigned OpW    = 6,
    parameter int unsigned AluLat = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [OpW-1:0]   req0_op_i,
    input  logic [DataW-1:0] req0_a_i,
    input  logic [DataW-1:0] req0_b_i,
    output logic             rsp0_valid_o,
    output logic [DataW-1:0] rsp0_data_o,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [OpW-1:0]   req1_op_i,
    input  logic [DataW-1:0] req1_a_i,
    input  logic [DataW-1:0] req1_b_i,
    output logic             rsp1_valid_o,
    output logic [DataW-1:0] rsp1_data_o,

    output logic [OpW-1:0]   alu_opcode_o,
    output logic [DataW-1:0] alu_in1_o,
    output logic [DataW-1:0] alu_in2_o,
    input  logic [DataW-1:0] alu_result_i,
    output logic             busy_o
);

    if (AluLat < 1 || AluLat > 7) begin : gen_lat_check
        $fatal(1, "AluLat must be in 1..7");
    end

    arb_state_e       state_q;
    logic             last_grant_q;
    logic             id_q;
    logic [CntW-1:0]  cnt_q;
    logic [OpW-1:0]   op_q;
    logic [DataW-1:0] a_q;
    logic [DataW-1:0] b_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [DataW-1:0] rsp0_data_q;
    logic [DataW-1:0] rsp1_data_q;
    logic             grant_id;

    // Ready is gated by reset so nothing can handshake while reset is held.
    always_comb begin
        grant_id     = arb_grant(req0_valid_i, req1_valid_i, last_grant_q);
        req0_ready_o = rst_ni && (state_q == ArbIdle) && req0_valid_i && !grant_id;
        req1_ready_o = rst_ni && (state_q == ArbIdle) && req1_valid_i && grant_id;
    end

    // The pin registers double as the latched request: loaded on handshake,
    // held through ISSUE/WAIT, returned to NOP/0 when the result is captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ArbIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            op_q         <= OpW'(AluNop);
            a_q          <= '0;
            b_q          <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            unique case (state_q)
                ArbIdle: begin
                    if (req0_ready_o || req1_ready_o) begin
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        op_q         <= grant_id ? req1_op_i : req0_op_i;
                        a_q          <= grant_id ? req1_a_i : req0_a_i;
                        b_q          <= grant_id ? req1_b_i : req0_b_i;
                        state_q      <= ArbIssue;
                    end
                end
                ArbIssue: begin
                    cnt_q   <= CntW'(AluLat);
                    state_q <= ArbWait;
                end
                ArbWait: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        if (id_q) begin
                            rsp1_data_q  <= alu_result_i;
                            rsp1_valid_q <= 1'b1;
                        end else begin
                            rsp0_data_q  <= alu_result_i;
                            rsp0_valid_q <= 1'b1;
                        end
                        op_q    <= OpW'(AluNop);
                        a_q     <= '0;
                        b_q     <= '0;
                        state_q <= ArbResp;
                    end
                end
                ArbResp: begin
                    state_q <= ArbIdle;
                end
                default: begin
                    state_q <= ArbIdle;
                end
            endcase
        end
    end

    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp0_data_o  = rsp0_data_q;
    assign rsp1_data_o  = rsp1_data_q;
    assign alu_opcode_o = op_q;
    assign alu_in1_o    = a_q;
    assign alu_in2_o    = b_q;
    assign busy_o       = (state_q != ArbIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at latency 1 and one at latency 3,
// each paired with a behavioural registered ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Latency-1 instance
    logic       a_r0v, a_r0r, a_s0v, a_r1v, a_r1r, a_s1v, a_busy;
    logic [5:0] a_r0op, a_r1op, a_aop;
    logic [7:0] a_r0a, a_r0b, a_r1a, a_r1b, a_s0d, a_s1d, a_in1, a_in2, a_res;

    // Latency-3 instance
    logic       b_r0v, b_r0r, b_s0v, b_r1v, b_r1r, b_s1v, b_busy;
    logic [5:0] b_r0op, b_r1op, b_aop;
    logic [7:0] b_r0a, b_r0b, b_r1a, b_r1b, b_s0d, b_s1d, b_in1, b_in2, b_res;
    logic [7:0] b_pipe [3];

    alu_arbiter #(.DataW(8), .OpW(6), .AluLat(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(a_r0v), .req0_ready_o(a_r0r), .req0_op_i(a_r0op),
        .req0_a_i(a_r0a), .req0_b_i(a_r0b), .rsp0_valid_o(a_s0v), .rsp0_data_o(a_s0d),
        .req1_valid_i(a_r1v), .req1_ready_o(a_r1r), .req1_op_i(a_r1op),
        .req1_a_i(a_r1a), .req1_b_i(a_r1b), .rsp1_valid_o(a_s1v), .rsp1_data_o(a_s1d),
        .alu_opcode_o(a_aop), .alu_in1_o(a_in1), .alu_in2_o(a_in2),
        .alu_result_i(a_res), .busy_o(a_busy)
    );

    alu_arbiter #(.DataW(8), .OpW(6), .AluLat(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(b_r0v), .req0_ready_o(b_r0r), .req0_op_i(b_r0op),
        .req0_a_i(b_r0a), .req0_b_i(b_r0b), .rsp0_valid_o(b_s0v), .rsp0_data_o(b_s0d),
        .req1_valid_i(b_r1v), .req1_ready_o(b_r1r), .req1_op_i(b_r1op),
        .req1_a_i(b_r1a), .req1_b_i(b_r1b), .rsp1_valid_o(b_s1v), .rsp1_data_o(b_s1d),
        .alu_opcode_o(b_aop), .alu_in1_o(b_in1), .alu_in2_o(b_in2),
        .alu_result_i(b_res), .busy_o(b_busy)
    );

    function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] x,
                                          input logic [7:0] y);
        case (op)
            AluAdda: return x + y;
            AluSuba: return x - y;
            AluAnda: return x & y;
            AluOra:  return x | y;
            AluAsla: return {x[6:0], 1'b0};
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        a_res     <= alu_fn(a_aop, a_in1, a_in2);
        b_pipe[0] <= alu_fn(b_aop, b_in1, b_in2);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_res = b_pipe[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    int   c0, c1;
    logic win;

    initial begin
        n_assert = 0; n_fail = 0;
        rst_n = 1'b0;
        a_r0v = 1'b1; a_r1v = 1'b1; b_r0v = 1'b0; b_r1v = 1'b0;
        a_r0op = AluAdda; a_r1op = AluAdda; b_r0op = AluNop; b_r1op = AluNop;
        a_r0a = '0; a_r0b = '0; a_r1a = '0; a_r1b = '0;
        b_r0a = '0; b_r0b = '0; b_r1a = '0; b_r1b = '0;

        // Reset state, with requests asserted to prove ready stays low
        negs(2); #1;
        chk("rst_ready0", 32'(a_r0r), 0);
        chk("rst_ready1", 32'(a_r1r), 0);
        chk("rst_rsp0v", 32'(a_s0v), 0);
        chk("rst_rsp1v", 32'(a_s1v), 0);
        chk("rst_rsp0d", 32'(a_s0d), 0);
        chk("rst_rsp1d", 32'(a_s1d), 0);
        chk("rst_aluop", 32'(a_aop), 32'h3F);
        chk("rst_in1", 32'(a_in1), 0);
        chk("rst_in2", 32'(a_in2), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_aluop_b", 32'(b_aop), 32'h3F);
        a_r0v = 1'b0; a_r1v = 1'b0;
        rst_n = 1'b1;
        negs(1);

        // Single request on port 0: ADDA 21+5
        a_r0op = AluAdda; a_r0a = 8'd21; a_r0b = 8'd5; a_r0v = 1'b1; #1;
        chk("t1_ready0", 32'(a_r0r), 1);
        chk("t1_ready1", 32'(a_r1r), 0);
        chk("t1_busy_T", 32'(a_busy), 0);
        negs(1); a_r0v = 1'b0; #1;
        chk("t1_busy_T1", 32'(a_busy), 1);
        chk("t1_ready0_issue", 32'(a_r0r), 0);
        chk("t1_pin_op", 32'(a_aop), 32'(AluAdda));
        chk("t1_pin_in1", 32'(a_in1), 21);
        chk("t1_pin_in2", 32'(a_in2), 5);
        negs(1);
        chk("t1_busy_T2", 32'(a_busy), 1);
        chk("t1_rsp0v_T2", 32'(a_s0v), 0);
        negs(1);
        chk("t1_rsp0v_T3", 32'(a_s0v), 1);
        chk("t1_rsp0d", 32'(a_s0d), 26);
        chk("t1_rsp1v", 32'(a_s1v), 0);
        chk("t1_busy_T3", 32'(a_busy), 1);
        chk("t1_pin_nop", 32'(a_aop), 32'h3F);
        negs(1);
        chk("t1_rsp0v_T4", 32'(a_s0v), 0);
        chk("t1_busy_T4", 32'(a_busy), 0);
        chk("t1_rsp0d_hold", 32'(a_s0d), 26);

        // Port 1 alone: SUBA 21-5
        a_r1op = AluSuba; a_r1a = 8'd21; a_r1b = 8'd5; a_r1v = 1'b1; #1;
        chk("t2_ready1", 32'(a_r1r), 1);
        chk("t2_ready0", 32'(a_r0r), 0);
        negs(1); a_r1v = 1'b0;
        negs(2);
        chk("t2_rsp1v", 32'(a_s1v), 1);
        chk("t2_rsp1d", 32'(a_s1d), 16);
        chk("t2_rsp0v", 32'(a_s0v), 0);
        negs(1);

        // Tie right after reset: port 0 first, port 1 handshakes at T+4
        rst_n = 1'b0; negs(1); rst_n = 1'b1; negs(1);
        a_r0op = AluAnda; a_r0a = 8'd13; a_r0b = 8'd5; a_r0v = 1'b1;
        a_r1op = AluOra;  a_r1a = 8'd13; a_r1b = 8'd5; a_r1v = 1'b1; #1;
        chk("t3_ready0", 32'(a_r0r), 1);
        chk("t3_ready1", 32'(a_r1r), 0);
        negs(1); a_r0v = 1'b0; #1;
        chk("t3_ready1_busy", 32'(a_r1r), 0);
        negs(2);
        chk("t3_rsp0v", 32'(a_s0v), 1);
        chk("t3_rsp0d", 32'(a_s0d), 5);
        chk("t3_rsp1v_early", 32'(a_s1v), 0);
        negs(1); #1;
        chk("t3_ready1_T4", 32'(a_r1r), 1);
        chk("t3_ready0_T4", 32'(a_r0r), 0);
        negs(1); a_r1v = 1'b0;
        negs(2);
        chk("t3_rsp1v_T7", 32'(a_s1v), 1);
        chk("t3_rsp1d_T7", 32'(a_s1d), 13);
        chk("t3_rsp0v_T7", 32'(a_s0v), 0);
        negs(1);

        // Saturation: both ports always valid; last winner was port 1
        c0 = 0; c1 = 0;
        a_r0op = AluAdda; a_r0a = 8'd0;   a_r0b = 8'd10; a_r0v = 1'b1;
        a_r1op = AluSuba; a_r1a = 8'd100; a_r1b = 8'd0;  a_r1v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            win = 1'(i % 2);
            #1;
            chk("sat_ready0", 32'(a_r0r), 32'(!win));
            chk("sat_ready1", 32'(a_r1r), 32'(win));
            negs(1);
            if (!win) begin
                c0++; a_r0a = 8'(c0);
            end else begin
                c1++; a_r1b = 8'(c1);
            end
            negs(2);
            if (!win) begin
                chk("sat_rsp0v", 32'(a_s0v), 1);
                chk("sat_rsp0d", 32'(a_s0d), 32'(c0 - 1 + 10));
                chk("sat_rsp1v_quiet", 32'(a_s1v), 0);
            end else begin
                chk("sat_rsp1v", 32'(a_s1v), 1);
                chk("sat_rsp1d", 32'(a_s1d), 32'(100 - (c1 - 1)));
                chk("sat_rsp0v_quiet", 32'(a_s0v), 0);
            end
            negs(1);
        end
        a_r0v = 1'b0; a_r1v = 1'b0;

        // Reset during WAIT aborts the transaction
        a_r0op = AluAdda; a_r0a = 8'd1; a_r0b = 8'd2; a_r0v = 1'b1; #1;
        chk("t5_ready0", 32'(a_r0r), 1);
        negs(2); #1;
        chk("t5_busy_wait", 32'(a_busy), 1);
        #2 rst_n = 1'b0; #1;
        chk("t5_busy_rst", 32'(a_busy), 0);
        chk("t5_aluop_rst", 32'(a_aop), 32'h3F);
        chk("t5_in1_rst", 32'(a_in1), 0);
        chk("t5_in2_rst", 32'(a_in2), 0);
        chk("t5_ready0_rst", 32'(a_r0r), 0);
        chk("t5_rsp0v_rst", 32'(a_s0v), 0);
        chk("t5_rsp0d_rst", 32'(a_s0d), 0);
        for (int k = 0; k < 4; k++) begin
            negs(1);
            chk("t5_no_rsp0", 32'(a_s0v), 0);
            chk("t5_no_rsp1", 32'(a_s1v), 0);
        end
        rst_n = 1'b1;
        a_r1op = AluOra; a_r1a = 8'd13; a_r1b = 8'd5; a_r1v = 1'b1; #1;
        chk("t5_tie_ready0", 32'(a_r0r), 1);
        chk("t5_tie_ready1", 32'(a_r1r), 0);
        negs(1); a_r0v = 1'b0;
        negs(2);
        chk("t5_rsp0v", 32'(a_s0v), 1);
        chk("t5_rsp0d", 32'(a_s0d), 3);
        chk("t5_rsp1v", 32'(a_s1v), 0);
        negs(1);
        negs(1); a_r1v = 1'b0;
        negs(2);
        chk("t5_rsp1v_next", 32'(a_s1v), 1);
        chk("t5_rsp1d_next", 32'(a_s1d), 13);
        negs(1);

        // Latency-3 instance: ASLA 4 -> 8 at T+5
        b_r0op = AluAsla; b_r0a = 8'd4; b_r0b = 8'd0; b_r0v = 1'b1; #1;
        chk("l3_ready0", 32'(b_r0r), 1);
        negs(1); b_r0v = 1'b0; #1;
        chk("l3_issue_op", 32'(b_aop), 32'(AluAsla));
        chk("l3_issue_in1", 32'(b_in1), 4);
        for (int k = 0; k < 3; k++) begin
            negs(1);
            chk("l3_wait_op", 32'(b_aop), 32'(AluAsla));
            chk("l3_wait_in1", 32'(b_in1), 4);
            chk("l3_wait_rsp0v", 32'(b_s0v), 0);
            chk("l3_wait_busy", 32'(b_busy), 1);
        end
        negs(1);
        chk("l3_rsp0v", 32'(b_s0v), 1);
        chk("l3_rsp0d", 32'(b_s0d), 8);
        chk("l3_rsp1v", 32'(b_s1v), 0);
        chk("l3_resp_nop", 32'(b_aop), 32'h3F);
        chk("l3_resp_in1", 32'(b_in1), 0);
        negs(1);
        chk("l3_idle_busy", 32'(b_busy), 0);
        chk("l3_idle_rsp0v", 32'(b_s0v), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
